multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM controller that sequences the shared RISC-V datapath over multiple cycles: one ALU, one unified memory port, and a register file with an external instruction register (IR).
- Supports lw, sw, R-type (add/sub/and/or/slt), addi, beq and jal.
- Sits between the IR/flags and the datapath muxes and enables.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- COUNT_WIDTH, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Instr  input  32  IR contents; valid from DECODE until the next FETCH completes.
- Zero  input  1  ALU zero flag, same cycle.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR and OldPC capture enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  ALU B: 00 = rs2, 01 = immediate, 10 = constant 4.
- ALUctrl  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal  output  1  one-cycle pulse on unsupported opcode.
- instr_count  output  COUNT_WIDTH  retired-instruction count.

Behaviour:
- Reset:
  - Asynchronous; state becomes FETCH and instr_count becomes 0.
  - While rst=1, PCWrite, MemWrite, IRWrite, RegWrite and illegal are forced 0.
  - Other outputs take their FETCH values.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Default for every output not listed in a state is 0 (ALUctrl = add).
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUctrl add.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut).
  - Next state by Op=Instr[6:0]:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> FETCH with illegal=1 for that cycle; not counted as retired.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state MEMREAD if Op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE:
  - AdrSrc=1, MemWrite=1 held for every cycle until mem_ready=1.
  - Then FETCH; sw retires in that mem_ready cycle.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUctrl from funct decode. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUctrl from funct decode with funct7 ignored. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=Zero.
  - Next state FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - Next state ALUWB, which writes PC+4 to rd.
- Funct decode for R-type and addi:
  - funct3 000 -> add, or sub if Instr[30]=1 and Op[5]=1.
  - funct3 010 -> slt.
  - funct3 110 -> or.
  - funct3 111 -> and.
  - Any other funct3 -> add. No illegal flag for unsupported funct3.
- ImmSrc decoded combinationally from Op in all states:
  - lw/addi 00, sw 01, beq 10, jal 11, others 00.
- instr_count:
  - Increments by 1 on the final cycle of each legal instruction: MEMWB, ALUWB, BEQ, and MEMWRITE with mem_ready=1.
  - JAL counts only at its ALUWB.
  - Wraps modulo 2^COUNT_WIDTH.
- mem_ready is ignored in all states except FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction aborts it: no further enables assert, the count is not incremented, and the FSM restarts at FETCH.
- Latencies with mem_ready tied to 1:
  - lw 5 cycles; sw 4; R-type and addi 4; beq 3; jal 4 (FETCH, DECODE, JAL, ALUWB).

Test Plan:
- mem_ready=1; add x3,x1,x2 (0x002081B3) -> states FETCH, DECODE, EXECR, ALUWB; ALUctrl=000, RegWrite=1 only in cycle 4; instr_count 0->1.
- sub 0x402081B3, then slt funct3=010, and, or -> ALUctrl 001, 101, 010, 011 in EXECR; addi with Instr[30]=1 -> ALUctrl 000.
- lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles; RegWrite=1 with ResultSrc=01 exactly once; total 8 cycles.
- sw with mem_ready low for 2 cycles -> MemWrite=1 for 3 consecutive cycles, AdrSrc=1; count increments on the mem_ready cycle.
- beq with Zero=1 then Zero=0 -> PCWrite=1, then PCWrite=0, in the BEQ state; ALUctrl=001; each takes 3 cycles.
- Opcode 0x7F -> illegal pulses in DECODE, next state FETCH, no count; rst asserted during MEMWRITE -> MemWrite drops immediately and state=FETCH.

Source files
------------

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Moore-style controller for a multi-cycle RISC-V datapath. It shares one
//   ALU, one unified memory port and a register file, and sequences lw, sw,
//   R-type (add/sub/and/or/slt), addi, beq and jal over several cycles. It
//   stalls on a memory ready handshake and counts retired instructions.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   Instr        instruction register contents
//   Zero         ALU zero flag
//   mem_ready    memory finishes the current access this cycle
//   PCWrite      PC register enable
//   AdrSrc       memory address select (0 = PC, 1 = ALUOut)
//   MemWrite     memory write strobe
//   IRWrite      IR / OldPC capture enable
//   RegWrite     register file write enable
//   ResultSrc    result mux (00 ALUOut, 01 mem data, 10 ALUResult)
//   ALUSrcA      ALU A select (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB      ALU B select (00 rs2, 01 imm, 10 constant 4)
//   ALUctrl      ALU operation
//   ImmSrc       immediate format (00 I, 01 S, 10 B, 11 J)
//   illegal      one-cycle pulse on an unsupported opcode
//   instr_count  retired-instruction counter
// ----------------------------------------------------------------------------
module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            Instr,
    input  logic                   Zero,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   AdrSrc,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegWrite,
    output logic [1:0]             ResultSrc,
    output logic [1:0]             ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ALUctrl,
    output logic [1:0]             ImmSrc,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t                  r_state;
    state_t                  w_next;
    logic [6:0]              w_op;
    logic [2:0]              w_funct_alu;
    logic                    w_retire;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    w_unused_bits;

    // Only opcode, funct3 and bit 30 steer the controller.
    assign w_op          = Instr[6:0];
    assign w_unused_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

    // sub only for R-type with bit 30 set; addi ignores funct7 because Op[5]=0.
    function automatic logic [2:0] funct_decode(input logic [2:0] f3,
                                                input logic       b30,
                                                input logic       op5);
        case (f3)
            3'b000:  funct_decode = (b30 && op5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_decode = ALU_SLT;
            3'b110:  funct_decode = ALU_OR;
            3'b111:  funct_decode = ALU_AND;
            default: funct_decode = ALU_ADD;
        endcase
    endfunction

    assign w_funct_alu = funct_decode(Instr[14:12], Instr[30], w_op[5]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = w_op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUctrl   = ALU_ADD;
        illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (w_op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal = 1'b0;
                    default:                                  illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUctrl = w_funct_alu;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUctrl = w_funct_alu;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUctrl = ALU_SUB;
                PCWrite = Zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset holds the state at FETCH, but FETCH enables follow mem_ready,
        // so every side-effecting strobe is masked while rst is high.
        if (rst) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (w_op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Final cycle of each legal instruction; jal retires through ALUWB.
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                      (r_state == S_BEQ)   ||
                      ((r_state == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_count <= '0;
        else if (w_retire) r_count <= r_count + COUNT_WIDTH'(1);
    end

    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr;
    logic        Zero;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUctrl;
    logic [31:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control #(.COUNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl), .ImmSrc(ImmSrc), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUctrl, illegal}
    logic [16:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUctrl, illegal};

    function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, ill};
    endfunction

    // Expected control vectors per state, written from the state table.
    function automatic logic [16:0] v_fetch(input logic mr);
        return ev(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
    endfunction
    function automatic logic [16:0] v_decode(input logic ill);
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, ill);
    endfunction
    function automatic logic [16:0] v_execr(input logic [2:0] alu);
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0);
    endfunction
    function automatic logic [16:0] v_execi(input logic [2:0] alu);
        return ev(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0);
    endfunction
    function automatic logic [16:0] v_beq(input logic z);
        return ev(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
    endfunction

    localparam logic [16:0] V_MEMADR = 17'b0_0_0_0_0_00_10_01_000_0;
    localparam logic [16:0] V_MEMRD  = 17'b0_1_0_0_0_00_00_00_000_0;
    localparam logic [16:0] V_MEMWB  = 17'b0_0_0_0_1_01_00_00_000_0;
    localparam logic [16:0] V_MEMWR  = 17'b0_1_1_0_0_00_00_00_000_0;
    localparam logic [16:0] V_ALUWB  = 17'b0_0_0_0_1_00_00_00_000_0;
    localparam logic [16:0] V_JAL    = 17'b1_0_0_0_0_00_01_10_000_0;
    localparam logic [16:0] V_RESET  = 17'b0_0_0_0_0_10_00_10_000_0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Inputs are applied at the falling edge; outputs checked 1 time unit later.
    task automatic cyc(input string tag, input logic [16:0] e, input logic [31:0] cnt,
                       input logic [1:0] imm);
        #1;
        chk({tag, "_ctl"}, 32'(obs), 32'(e));
        chk({tag, "_cnt"}, instr_count, cnt);
        chk({tag, "_imm"}, 32'(ImmSrc), 32'(imm));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_r(input string tag, input logic [31:0] ins, input logic [2:0] alu,
                        input logic [31:0] cnt);
        Instr = ins;
        cyc({tag, "_fetch"}, v_fetch(1), cnt, 2'b00);
        cyc({tag, "_decode"}, v_decode(0), cnt, 2'b00);
        cyc({tag, "_execr"}, v_execr(alu), cnt, 2'b00);
        cyc({tag, "_aluwb"}, V_ALUWB, cnt, 2'b00);
    endtask

    initial begin
        rst = 1'b1; Instr = 32'h0; Zero = 1'b0; mem_ready = 1'b1;
        #2;
        chk("reset_ctl", 32'(obs), 32'(V_RESET));
        chk("reset_cnt", instr_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // R-type sequence
        do_r("add", 32'h002081B3, 3'b000, 0);
        do_r("sub", 32'h402081B3, 3'b001, 1);
        do_r("slt", 32'h0020A1B3, 3'b101, 2);
        do_r("and", 32'h0020F1B3, 3'b010, 3);
        do_r("or",  32'h0020E1B3, 3'b011, 4);

        // addi with bit 30 set stays add
        Instr = 32'h40008093;
        cyc("addi_fetch", v_fetch(1), 5, 2'b00);
        cyc("addi_decode", v_decode(0), 5, 2'b00);
        cyc("addi_execi", v_execi(3'b000), 5, 2'b00);
        cyc("addi_aluwb", V_ALUWB, 5, 2'b00);

        // lw with three wait cycles in MEMREAD
        Instr = 32'h0000A183;
        cyc("lw_fetch", v_fetch(1), 6, 2'b00);
        cyc("lw_decode", v_decode(0), 6, 2'b00);
        cyc("lw_memadr", V_MEMADR, 6, 2'b00);
        mem_ready = 1'b0;
        cyc("lw_memrd0", V_MEMRD, 6, 2'b00);
        cyc("lw_memrd1", V_MEMRD, 6, 2'b00);
        cyc("lw_memrd2", V_MEMRD, 6, 2'b00);
        mem_ready = 1'b1;
        cyc("lw_memrd3", V_MEMRD, 6, 2'b00);
        cyc("lw_memwb", V_MEMWB, 6, 2'b00);

        // sw with a fetch stall and two write wait cycles
        Instr = 32'h0030A023;
        mem_ready = 1'b0;
        cyc("sw_fetch_stall", v_fetch(0), 7, 2'b01);
        mem_ready = 1'b1;
        cyc("sw_fetch", v_fetch(1), 7, 2'b01);
        cyc("sw_decode", v_decode(0), 7, 2'b01);
        cyc("sw_memadr", V_MEMADR, 7, 2'b01);
        mem_ready = 1'b0;
        cyc("sw_memwr0", V_MEMWR, 7, 2'b01);
        cyc("sw_memwr1", V_MEMWR, 7, 2'b01);
        mem_ready = 1'b1;
        cyc("sw_memwr2", V_MEMWR, 7, 2'b01);

        // beq taken then not taken
        Instr = 32'h00208463;
        Zero = 1'b1;
        cyc("beq1_fetch", v_fetch(1), 8, 2'b10);
        cyc("beq1_decode", v_decode(0), 8, 2'b10);
        cyc("beq1_beq", v_beq(1), 8, 2'b10);
        Zero = 1'b0;
        cyc("beq0_fetch", v_fetch(1), 9, 2'b10);
        cyc("beq0_decode", v_decode(0), 9, 2'b10);
        cyc("beq0_beq", v_beq(0), 9, 2'b10);

        // jal
        Instr = 32'h0080006F;
        cyc("jal_fetch", v_fetch(1), 10, 2'b11);
        cyc("jal_decode", v_decode(0), 10, 2'b11);
        cyc("jal_jal", V_JAL, 10, 2'b11);
        cyc("jal_aluwb", V_ALUWB, 10, 2'b11);

        // unsupported opcode
        Instr = 32'h0000007F;
        cyc("ill_fetch", v_fetch(1), 11, 2'b00);
        cyc("ill_decode", v_decode(1), 11, 2'b00);
        cyc("ill_refetch", v_fetch(1), 11, 2'b00);

        // reset in the middle of a store
        Instr = 32'h0030A023;
        cyc("swr_decode", v_decode(0), 11, 2'b01);
        cyc("swr_memadr", V_MEMADR, 11, 2'b01);
        mem_ready = 1'b0;
        cyc("swr_memwr0", V_MEMWR, 11, 2'b01);
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("swr_rst_ctl", 32'(obs), 32'(V_RESET));
        chk("swr_rst_cnt", instr_count, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc("post_rst_fetch", v_fetch(1), 0, 2'b01);
        cyc("post_rst_decode", v_decode(0), 0, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
